// File: rtl/sqrt_nr_refine_if.sv
// rtl/sqrt_nr_refine_if.sv - operand/result handshake bundle for the square-root refinement stage
//
// Signals:
//   in_valid/in_ready     operand handshake (a = radicand, approx = estimated root)
//   out_valid/out_ready   result handshake (root, rem, iters)
// Modports:
//   master  upstream/downstream side (drives operands, consumes results)
//   slave   the refinement stage itself
interface sqrt_nr_refine_if #(
    parameter int ITER_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       a;
    logic [15:0]       approx;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       root;
    logic [16:0]       rem;
    logic [ITER_W-1:0] iters;

    modport master (
        output in_valid, a, approx, out_ready,
        input  in_ready, out_valid, root, rem, iters
    );

    modport slave (
        input  in_valid, a, approx, out_ready,
        output in_ready, out_valid, root, rem, iters
    );
endinterface

// File: rtl/sqrt_nr_refine.sv
// rtl/sqrt_nr_refine.sv - Newton-Raphson integer square-root refinement stage
//
// Refines an approximate 16-bit root of a 32-bit radicand with Newton steps
// r' = (r + A/r) >> 1, using a bit-serial restoring divider (32 cycles per
// division), then nudges r by +/-1 until it is exactly floor(sqrt(A)).
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of sqrt_nr_refine_if:
//           in_valid/in_ready, a[31:0], approx[15:0]           operand in
//           out_valid/out_ready, root[15:0], rem[16:0], iters   result out
module sqrt_nr_refine #(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    sqrt_nr_refine_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        UPDATE,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    // Operand and working root
    logic [31:0]       a_reg;
    logic [15:0]       r;
    logic [ITER_W-1:0] iter;

    // Restoring divider state
    logic [4:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] quo;
    logic [15:0] prem;
    logic [16:0] trial;
    logic        trial_ge;

    // Newton update
    logic [32:0] s_sum;
    logic [31:0] rn_wide;
    logic [15:0] rn;
    logic        close;
    logic        last_iter;

    // Correction (single 16x16 multiplier shared by FIX and the remainder)
    logic [31:0] sq;
    logic [33:0] sq_next;
    logic        fix_dec;
    logic        fix_inc;
    logic [16:0] rem_now;

    // Registered result, loaded once on entry to DONE
    logic [15:0]       root_q;
    logic [16:0]       rem_q;
    logic [ITER_W-1:0] iters_q;

    // The partial remainder is always < r, so shifting in one dividend bit
    // needs 17 bits for the trial compare.
    assign trial    = {prem, dvd[31]};
    assign trial_ge = trial >= {1'b0, r};

    // q can be 0xFFFFFFFF when r=1; the 33-bit sum keeps the carry.
    assign s_sum     = {1'b0, quo} + {17'b0, r};
    assign rn_wide   = 32'(s_sum >> 1);
    assign rn        = (rn_wide[31:16] != 16'd0) ? 16'hFFFF : rn_wide[15:0];
    assign close     = (rn >= r) ? ((rn - r) <= 16'd1) : ((r - rn) <= 16'd1);
    assign last_iter = (iter == ITER_W'(MAX_ITER));

    // (r+1)^2 = r^2 + 2r + 1 reuses the one product.
    assign sq      = 32'(r) * 32'(r);
    assign sq_next = {2'b0, sq} + {17'b0, r, 1'b0} + 34'd1;
    assign fix_dec = sq > a_reg;
    assign fix_inc = (r != 16'hFFFF) && (sq_next <= {2'b0, a_reg});
    assign rem_now = 17'(a_reg - sq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = (bus.a == 32'd0) ? DONE : DIV;
                end
            end
            DIV: begin
                if (cnt == 5'd31) begin
                    state_n = UPDATE;
                end
            end
            UPDATE: begin
                state_n = (close || last_iter) ? FIX : DIV;
            end
            FIX: begin
                if (!fix_dec && !fix_inc) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= 32'd0;
            r       <= 16'd0;
            iter    <= '0;
            cnt     <= 5'd0;
            dvd     <= 32'd0;
            quo     <= 32'd0;
            prem    <= 16'd0;
            root_q  <= 16'd0;
            rem_q   <= 17'd0;
            iters_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        if (bus.a == 32'd0) begin
                            r       <= 16'd0;
                            iter    <= '0;
                            root_q  <= 16'd0;
                            rem_q   <= 17'd0;
                            iters_q <= '0;
                        end else begin
                            // approx==0 would divide by zero; 1 is a safe seed.
                            r    <= (bus.approx == 16'd0) ? 16'd1 : bus.approx;
                            iter <= ITER_W'(1);
                            cnt  <= 5'd0;
                            dvd  <= bus.a;
                            quo  <= 32'd0;
                            prem <= 16'd0;
                        end
                    end
                end
                DIV: begin
                    prem <= trial_ge ? 16'(trial - {1'b0, r}) : trial[15:0];
                    quo  <= {quo[30:0], trial_ge};
                    dvd  <= {dvd[30:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                end
                UPDATE: begin
                    r <= rn;
                    if (!(close || last_iter)) begin
                        iter <= iter + ITER_W'(1);
                        cnt  <= 5'd0;
                        dvd  <= a_reg;
                        quo  <= 32'd0;
                        prem <= 16'd0;
                    end
                end
                FIX: begin
                    if (fix_dec) begin
                        r <= r - 16'd1;
                    end else if (fix_inc) begin
                        r <= r + 16'd1;
                    end else begin
                        root_q  <= r;
                        rem_q   <= rem_now;
                        iters_q <= iter;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
    assign bus.iters     = iters_q;

endmodule

// File: tb/tb_sqrt_nr_refine.sv
// tb/tb_sqrt_nr_refine.sv - self-checking bench for sqrt_nr_refine
module tb_sqrt_nr_refine;

    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 4;

    logic clk;
    logic rst;

    int tests;
    int fails;

    sqrt_nr_refine_if #(.ITER_W(ITER_W)) sif ();

    sqrt_nr_refine #(
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint isqrt(input longint v);
        longint x;
        x = longint'($floor($sqrt(real'(v))));
        while (x * x > v) x--;
        while ((x + 1) * (x + 1) <= v) x++;
        return x;
    endfunction

    // Newton iteration at the arithmetic level, plus the cycle cost of each phase.
    function automatic void model(input longint av, input longint apv,
                                  output longint root, output longint rem,
                                  output int it, output int lat);
        longint r, q, rn, steps;
        bit stop;
        if (av == 0) begin
            root = 0; rem = 0; it = 0; lat = 1;
            return;
        end
        r = (apv == 0) ? 1 : apv;
        it = 0;
        stop = 0;
        while (!stop) begin
            q = av / r;
            it++;
            rn = (r + q) / 2;
            if (rn > 65535) rn = 65535;
            stop = ((rn - r) <= 1 && (r - rn) <= 1) || (it == MAX_ITER);
            r = rn;
        end
        root  = isqrt(av);
        rem   = av - root * root;
        steps = (r > root) ? (r - root) : (root - r);
        lat   = 33 * it + int'(steps) + 2;
    endfunction

    task automatic run_op(input logic [31:0] av, input logic [15:0] apv, input bit consume,
                          output logic [15:0] r, output logic [16:0] m,
                          output logic [ITER_W-1:0] it, output int lat, output bit ok);
        int  n;
        bit  acc;
        ok  = 1;
        lat = 0;
        r   = '0;
        m   = '0;
        it  = '0;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.a        = av;
        sif.approx   = apv;
        n   = 0;
        acc = 0;
        while (!acc && n < 100) begin
            acc = sif.in_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        #1 sif.in_valid = 1'b0;
        if (!acc) begin
            ok = 0;
            return;
        end
        lat = 1;
        while (lat < 5000) begin
            @(negedge clk);
            if (sif.out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!sif.out_valid) begin
            ok = 0;
            return;
        end
        r  = sif.root;
        m  = sif.rem;
        it = sif.iters;
        if (consume) begin
            sif.out_ready = 1'b1;
            @(posedge clk);
            #1 sif.out_ready = 1'b0;
        end
    endtask

    logic [15:0]       gr;
    logic [16:0]       gm;
    logic [ITER_W-1:0] gi;
    int                gl;
    bit                gok;

    task automatic test_reset;
        rst = 1'b1;
        sif.in_valid  = 1'b0;
        sif.a         = '0;
        sif.approx    = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (sif.out_valid !== 1'b0 || sif.root !== 16'd0 || sif.rem !== 17'd0 || sif.iters !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got out_valid=%b root=%0d rem=%0d iters=%0d, want 0/0/0/0",
                     sif.out_valid, sif.root, sif.rem, sif.iters);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sif.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", sif.in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'h0001_0000, 32'd1000000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1};
        logic [15:0] tp [6] = '{16'h0100, 16'd900, 16'hFFFF, 16'd0, 16'd5, 16'hFFFF};
        int          er [6] = '{256, 1000, 65535, 1, 0, 1};
        int          em [6] = '{0, 0, 131070, 1, 0, 0};
        int          ei [6] = '{1, 3, 1, 1, 0, 8};
        int          el [6] = '{35, 101, 35, 35, 1, 520};
        for (int k = 0; k < 6; k++) begin
            run_op(ta[k], tp[k], 1'b1, gr, gm, gi, gl, gok);
            tests++;
            if (!gok) begin
                fails++;
                $display("FAIL directed%0d_timeout: handshake got ok=%0d want 1", k, gok);
                continue;
            end
            tests++;
            if (gr !== 16'(er[k])) begin
                fails++;
                $display("FAIL directed%0d_root: got %0d want %0d", k, gr, er[k]);
            end
            tests++;
            if (gm !== 17'(em[k])) begin
                fails++;
                $display("FAIL directed%0d_rem: got %0d want %0d", k, gm, em[k]);
            end
            tests++;
            if (gi !== ITER_W'(ei[k])) begin
                fails++;
                $display("FAIL directed%0d_iters: got %0d want %0d", k, gi, ei[k]);
            end
            tests++;
            if (gl != el[k]) begin
                fails++;
                $display("FAIL directed%0d_latency: got %0d want %0d", k, gl, el[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] av;
        logic [15:0] apv;
        longint      xr, xm, base;
        int          xi, xl, off;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: av = $urandom;
                1: av = $urandom_range(0, 1000);
                2: begin
                    base = longint'($urandom_range(0, 65535));
                    av = 32'(base * base + longint'($urandom_range(0, 2)) - 1);
                end
                default: av = (k % 8 == 0) ? 32'd0 : {$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 4095));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                apv = 16'($urandom);
            end else begin
                off  = int'($urandom_range(0, 6)) - 3;
                base = isqrt({32'd0, av}) + longint'(off);
                if (base < 0) base = 0;
                if (base > 65535) base = 65535;
                apv = 16'(base);
            end
            model({32'd0, av}, {48'd0, apv}, xr, xm, xi, xl);
            run_op(av, apv, 1'b1, gr, gm, gi, gl, gok);
            tests++;
            if (!gok || gr !== 16'(xr) || gm !== 17'(xm) || gi !== ITER_W'(xi) || gl != xl) begin
                fails++;
                $display("FAIL random%0d a=%h approx=%h: got ok=%0d root=%0d rem=%0d iters=%0d lat=%0d want root=%0d rem=%0d iters=%0d lat=%0d",
                         k, av, apv, gok, gr, gm, gi, gl, xr, xm, xi, xl);
            end
        end
    endtask

    task automatic test_backpressure;
        run_op(32'd1000000, 16'd1000, 1'b0, gr, gm, gi, gl, gok);
        tests++;
        if (!gok || gr !== 16'd1000 || gm !== 17'd0 || gi !== ITER_W'(1) || gl != 35) begin
            fails++;
            $display("FAIL bp_first: got ok=%0d root=%0d rem=%0d iters=%0d lat=%0d want 1000/0/1/35",
                     gok, gr, gm, gi, gl);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (sif.out_valid !== 1'b1 || sif.root !== 16'd1000 || sif.rem !== 17'd0 ||
                sif.iters !== ITER_W'(1) || sif.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got out_valid=%b root=%0d rem=%0d iters=%0d in_ready=%b want 1/1000/0/1/0",
                         c, sif.out_valid, sif.root, sif.rem, sif.iters, sif.in_ready);
            end
            sif.in_valid  = 1'b1;
            sif.a         = $urandom;
            sif.approx    = 16'($urandom);
            sif.out_ready = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1 sif.out_ready = 1'b0;
        tests++;
        if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", sif.out_valid, sif.in_ready);
        end
        run_op(32'h0001_0000, 16'h0100, 1'b1, gr, gm, gi, gl, gok);
        tests++;
        if (!gok || gr !== 16'd256 || gm !== 17'd0 || gi !== ITER_W'(1) || gl != 35) begin
            fails++;
            $display("FAIL bp_next: got ok=%0d root=%0d rem=%0d iters=%0d lat=%0d want 256/0/1/35",
                     gok, gr, gm, gi, gl);
        end
    endtask

    task automatic test_reset_mid_div;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.a        = 32'h1234_5678;
        sif.approx   = 16'h0010;
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (sif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstdiv_async: got out_valid=%b want 0", sif.out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0 || sif.root !== 16'd0 ||
            sif.rem !== 17'd0 || sif.iters !== '0) begin
            fails++;
            $display("FAIL rstdiv_idle: got in_ready=%b out_valid=%b root=%0d rem=%0d iters=%0d want 1/0/0/0/0",
                     sif.in_ready, sif.out_valid, sif.root, sif.rem, sif.iters);
        end
        run_op(32'd49, 16'd6, 1'b1, gr, gm, gi, gl, gok);
        tests++;
        if (!gok || gr !== 16'd7 || gm !== 17'd0 || gi !== ITER_W'(1) || gl != 35) begin
            fails++;
            $display("FAIL rstdiv_next: got ok=%0d root=%0d rem=%0d iters=%0d lat=%0d want 7/0/1/35",
                     gok, gr, gm, gi, gl);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
